// File: rtl/im_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed image over a byte stream,
// writes it into instruction memory, and releases the CPU once the image is verified.
module im_boot_loader #(
    parameter int MEM_BYTES     = 8192,
    parameter int ADDR_W        = 13,
    parameter bit BOOT_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              boot_start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic [31:0]       pc_in,
    output logic [31:0]       im_addr,
    output logic              im_we,
    output logic [7:0]        im_wdata,
    output logic              cpu_stall,
    output logic              boot_done,
    output logic              boot_err,
    output logic [ADDR_W:0]   byte_count
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;
    localparam state_t RST_STATE = BOOT_ON_RESET ? S_HDR : S_IDLE;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_live;
    logic [31:0]       r_len;
    logic [1:0]        r_hdr_idx;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_waddr;
    logic [7:0]        r_csum;
    logic              r_we;
    logic [7:0]        r_wdata;
    logic [ADDR_W:0]   r_count;

    logic              w_accept;
    logic              w_last_data;
    logic [31:0]       w_len_full;
    logic              w_rdy;
    logic              w_stall;
    logic              w_done;
    logic              w_err;

    assign w_accept    = rx_valid && rx_ready;
    assign w_len_full  = {rx_data, r_len[23:0]};
    // Pointer stops at L-1; the last payload byte is detected instead of overrunning.
    assign w_last_data = ({{(32-ADDR_W){1'b0}}, r_ptr} == (r_len - 32'd1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HDR: begin
                if (w_accept && (r_hdr_idx == 2'd3)) begin
                    if (w_len_full > 32'(MEM_BYTES)) begin
                        w_state_nxt = S_ERR;
                    end else if (w_len_full == 32'd0) begin
                        w_state_nxt = S_CSUM;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept && w_last_data) begin
                    w_state_nxt = S_CSUM;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_state_nxt = (rx_data == r_csum) ? S_RUN : S_ERR;
                end
            end
            default: ;
        endcase
        if (boot_start) begin
            w_state_nxt = S_HDR;
        end
    end

    always_comb begin
        w_rdy   = 1'b0;
        w_stall = 1'b1;
        w_done  = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            S_HDR, S_DATA, S_CSUM: w_rdy = 1'b1;
            S_RUN: begin
                w_stall = 1'b0;
                w_done  = 1'b1;
            end
            S_ERR:  w_err = 1'b1;
            default: ;
        endcase
    end

    // r_live keeps rx_ready low while reset is held, even though the reset state may be HDR.
    assign rx_ready   = w_rdy && r_live;
    assign cpu_stall  = w_stall;
    assign boot_done  = w_done;
    assign boot_err   = w_err;
    assign im_we      = r_we;
    assign im_wdata   = r_wdata;
    assign byte_count = r_count;
    assign im_addr    = r_we ? {{(32-ADDR_W){1'b0}}, r_waddr} : pc_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_live    <= 1'b0;
            r_len     <= '0;
            r_hdr_idx <= '0;
            r_ptr     <= '0;
            r_waddr   <= '0;
            r_csum    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_count   <= '0;
        end else begin
            r_live <= 1'b1;
            if (boot_start) begin
                r_len     <= '0;
                r_hdr_idx <= '0;
                r_ptr     <= '0;
                r_waddr   <= '0;
                r_csum    <= '0;
                r_we      <= 1'b0;
                r_wdata   <= '0;
                r_count   <= '0;
            end else begin
                r_we <= 1'b0;
                if (w_accept) begin
                    case (r_state)
                        S_HDR: begin
                            r_len[{r_hdr_idx, 3'b000} +: 8] <= rx_data;
                            r_hdr_idx <= r_hdr_idx + 2'd1;
                        end
                        S_DATA: begin
                            r_we    <= 1'b1;
                            r_wdata <= rx_data;
                            r_waddr <= r_ptr;
                            r_csum  <= r_csum ^ rx_data;
                            r_count <= r_count + (ADDR_W+1)'(1);
                            if (!w_last_data) begin
                                r_ptr <= r_ptr + ADDR_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
